lsu_align: RTL and testbench
============================

LSU_ALIGN -- requirements
Module: lsu_align

Interface
REQ-001 Parameter DM_ADDRESS, default 9, word-address width of the data memory port.
REQ-002 Parameter DATA_W, default 32, data width; only 32 is supported.
REQ-003 Port clk, input, 1, single clock for the block; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port req_valid, input, 1, the execute stage presents a memory request.
REQ-006 Port req_ready, output, 1, the block accepts a request this cycle.
REQ-007 Port req_we, input, 1, 1 = store, 0 = load.
REQ-008 Port req_funct3, input, 3, RISC-V width/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-009 Port req_addr, input, 32, byte address (ALU result).
REQ-010 Port req_wdata, input, DATA_W, store data, right-justified.
REQ-011 Port rsp_valid, output, 1, one-cycle pulse marking request completion.
REQ-012 Port rsp_rdata, output, DATA_W, extended load result; 0 for stores and errors.
REQ-013 Port rsp_err, output, 1, the funct3 was illegal for the access type; qualified by rsp_valid.
REQ-014 Port mem_addr, output, DM_ADDRESS, word address to the data memory.
REQ-015 Port mem_we, output, 1, memory write strobe, sampled by memory at the rising edge.
REQ-016 Port mem_be, output, 4, byte enables for a write; bit i corresponds to byte lane i.
REQ-017 Port mem_wdata, output, DATA_W, lane-aligned write data.
REQ-018 Port mem_rdata, input, DATA_W, memory read word, combinational from mem_addr in the same cycle.

Function
REQ-019 FSM states SHALL be IDLE, ACC0, ACC1 and DONE; req_ready SHALL be 1 only in IDLE.
REQ-020 A request SHALL be accepted on req_valid&&req_ready; addr/we/funct3/wdata registered, transition to ACC0.
REQ-021 Access fields: off=addr[1:0]; size=1/2/4 bytes by funct3[1:0]; word index W=addr[DM_ADDRESS+1:2].
REQ-022 Split access = off+size>4; ACC0 -> ACC1 if split, else ACC0 -> DONE; ACC1 -> DONE; DONE -> IDLE.
REQ-023 ACC0 SHALL drive mem_addr=W; ACC1 SHALL drive mem_addr=W+1 modulo 2^DM_ADDRESS (top word wraps to 0).
REQ-024 Store ACC0: mem_be=lane mask for bytes off..min(off+size,4)-1; mem_wdata=wdata<<(8*off).
REQ-025 Store ACC1: mem_be=lanes 0..off+size-5; mem_wdata=wdata>>(8*(4-off)).
REQ-026 mem_we SHALL be 1 only in ACC0/ACC1 of a legal store; otherwise mem_we=0 and mem_be=0.
REQ-027 Load: ACC0 SHALL capture mem_rdata>>(8*off) into the low result bytes.
REQ-028 Split load: ACC1 SHALL fill the remaining upper bytes from mem_rdata lanes 0..off+size-5.
REQ-029 Load extension: b/h sign-extend from bit 7/15; bu/hu zero-extend; w unmodified.
REQ-030 DONE SHALL assert rsp_valid for exactly one cycle with registered rsp_rdata/rsp_err; both hold stable otherwise.
REQ-031 Illegal codes (load 011/110/111; store funct3!=000/001/010) SHALL make no memory access; ACC0 -> DONE with rsp_err=1, rsp_rdata=0.
REQ-032 Latency from acceptance: aligned rsp_valid 2 cycles later; split 3 cycles later; next accept in IDLE after DONE.
REQ-033 A req_valid asserted outside IDLE SHALL be ignored and SHALL be held by the requester until req_ready.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE with rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, and req_ready=1 after release.
REQ-035 Reset mid-operation SHALL abort the request with no further mem_we pulse and no rsp_valid.

Verification
REQ-036 sw addr 0x10, wdata 0xDEADBEEF -> ACC0: mem_addr=4, be=1111, wdata=0xDEADBEEF, we=1; rsp_valid 2 cycles after accept, err=0.
REQ-037 lb addr 0x13, mem[4]=0x80AA5500 -> rsp_rdata=0xFFFFFF80; lbu same -> 0x00000080.
REQ-038 lw addr 0x0E, mem[3]=0x3344xxxx, mem[4]=0xxxxx1122 -> mem_addr 3 then 4, rsp_rdata=0x11223344, rsp_valid 3 cycles after accept.
REQ-039 sh addr 0x7FF (DM_ADDRESS=9), wdata 0xBEEF -> ACC0 addr 511 be=1000 wdata=0xEF000000; ACC1 addr 0 be=0001 wdata low byte 0xBE.
REQ-040 Store with funct3=100 -> no mem_we, rsp_err=1, rsp_rdata=0; next request accepted normally.
REQ-041 rst_n low during ACC0 of a split store -> mem_we=0 at once, no ACC1 write, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_align.sv
// Load/store alignment unit: turns byte-addressed b/h/w requests into one or two
// word accesses with byte enables, and assembles and extends load results.
module lsu_align #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and the requester holds req_valid and its
  // payload until that edge. rsp_valid is a one-cycle completion pulse.
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t                  state;
  logic                    r_we;
  logic [2:0]              r_funct3;
  logic [1:0]              r_off;
  logic [DM_ADDRESS-1:0]   r_word;
  logic [DATA_W-1:0]       r_wdata;
  logic                    r_split;
  logic                    r_err;
  logic [DATA_W-1:0]       r_buf;

  function automatic logic [2:0] size_of(input logic [1:0] code);
    case (code)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] mask_of(input logic [1:0] code);
    case (code)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else    return !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [2:0] f3, input logic [DATA_W-1:0] d);
    case (f3)
      3'b000:  return {{(DATA_W-8){d[7]}}, d[7:0]};
      3'b001:  return {{(DATA_W-16){d[15]}}, d[15:0]};
      3'b100:  return {{(DATA_W-8){1'b0}}, d[7:0]};
      3'b101:  return {{(DATA_W-16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  logic [DM_ADDRESS-1:0] in_word;
  logic                  in_legal;
  logic                  in_split;
  logic [7:0]            in_be_w;
  logic [7:0]            r_be_w;
  logic [2*DATA_W-1:0]   in_wd_w;
  logic [2*DATA_W-1:0]   r_wd_w;
  logic [2*DATA_W-1:0]   ld_single;
  logic [2*DATA_W-1:0]   ld_split;
  logic                  unused_bits;

  assign in_word  = req_addr[DM_ADDRESS+1:2];
  assign in_legal = is_legal(req_we, req_funct3);
  assign in_split = ({1'b0, req_addr[1:0]} + size_of(req_funct3[1:0])) > 3'd4;

  // Lane placement over a two-word window: the low half feeds ACC0, the high half ACC1.
  assign in_be_w = {4'b0000, mask_of(req_funct3[1:0])} << req_addr[1:0];
  assign in_wd_w = {{DATA_W{1'b0}}, req_wdata} << {req_addr[1:0], 3'b000};
  assign r_be_w  = {4'b0000, mask_of(r_funct3[1:0])} << r_off;
  assign r_wd_w  = {{DATA_W{1'b0}}, r_wdata} << {r_off, 3'b000};

  // Load assembly: shift the fetched word(s) down so the addressed byte lands in lane 0.
  assign ld_single = {{DATA_W{1'b0}}, mem_rdata} >> {r_off, 3'b000};
  assign ld_split  = {mem_rdata, r_buf} >> {r_off, 3'b000};

  assign unused_bits = ^{req_addr[31:DM_ADDRESS+2], in_be_w[7:4], in_wd_w[2*DATA_W-1:DATA_W],
                         r_be_w[3:0], r_wd_w[DATA_W-1:0], ld_single[2*DATA_W-1:DATA_W],
                         ld_split[2*DATA_W-1:DATA_W]};

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      r_we      <= 1'b0;
      r_funct3  <= 3'b000;
      r_off     <= 2'b00;
      r_word    <= '0;
      r_wdata   <= '0;
      r_split   <= 1'b0;
      r_err     <= 1'b0;
      r_buf     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_wdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            state    <= ACC0;
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_off    <= req_addr[1:0];
            r_word   <= in_word;
            r_wdata  <= req_wdata;
            r_err    <= !in_legal;
            r_split  <= in_legal && in_split;
            mem_addr <= in_word;
            if (in_legal && req_we) begin
              mem_we    <= 1'b1;
              mem_be    <= in_be_w[3:0];
              mem_wdata <= in_wd_w[DATA_W-1:0];
            end else begin
              mem_we <= 1'b0;
              mem_be <= 4'b0000;
            end
          end
        end
        ACC0: begin
          if (r_split) begin
            state    <= ACC1;
            r_buf    <= mem_rdata;
            mem_addr <= r_word + DM_ADDRESS'(1);
            if (r_we) begin
              mem_we    <= 1'b1;
              mem_be    <= r_be_w[7:4];
              mem_wdata <= r_wd_w[2*DATA_W-1:DATA_W];
            end else begin
              mem_we <= 1'b0;
              mem_be <= 4'b0000;
            end
          end else begin
            state     <= DONE;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            rsp_valid <= 1'b1;
            rsp_err   <= r_err;
            rsp_rdata <= (r_err || r_we) ? '0 : extend(r_funct3, ld_single[DATA_W-1:0]);
          end
        end
        ACC1: begin
          state     <= DONE;
          mem_we    <= 1'b0;
          mem_be    <= 4'b0000;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= r_we ? '0 : extend(r_funct3, ld_split[DATA_W-1:0]);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: byte-level reference memory model, response and write
// scoreboards, directed corner cases, reset abort and randomized traffic.
module tb_lsu_align;
  localparam int DMA = 9;
  localparam int W   = 32;
  localparam int NB  = 4 << DMA;

  logic           clk;
  logic           rst_n;
  logic           req_valid;
  logic           req_ready;
  logic           req_we;
  logic [2:0]     req_funct3;
  logic [31:0]    req_addr;
  logic [W-1:0]   req_wdata;
  logic           rsp_valid;
  logic [W-1:0]   rsp_rdata;
  logic           rsp_err;
  logic [DMA-1:0] mem_addr;
  logic           mem_we;
  logic [3:0]     mem_be;
  logic [W-1:0]   mem_wdata;
  logic [W-1:0]   mem_rdata;

  lsu_align #(.DM_ADDRESS(DMA), .DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- clock / reset / memory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] mem [0:(1<<DMA)-1];
  logic [7:0]   ref_mem [0:NB-1];

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk)
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];

  // ---------------- scoreboard state ----------------
  logic [W:0]      exp_q[$];
  int              exp_cyc_q[$];
  logic [DMA+35:0] wr_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  task automatic set_word(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int k = 0; k < 4; k++) ref_mem[4*w+k] = v[8*k +: 8];
  endtask

  // Reference model: byte-addressed memory semantics, computed per transaction.
  task automatic model_push(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd);
    logic           legal;
    int             off, size, ba, lane;
    logic           split;
    logic [31:0]    val, d0, d1;
    logic [3:0]     be0, be1;
    logic [DMA-1:0] w0, w1;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 inside {3'b000, 3'b001, 3'b010})
               : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    off   = int'(addr[1:0]);
    ba    = int'(addr[DMA+1:0]);
    split = legal && (off + size > 4);
    w0    = addr[DMA+1:2];
    w1    = w0 + 1'b1;
    if (!legal) begin
      exp_q.push_back({1'b1, 32'h0});
    end else if (we) begin
      be0 = 4'b0000;
      be1 = 4'b0000;
      for (int i = 0; i < size; i++) begin
        lane = off + i;
        if (lane < 4) be0[lane] = 1'b1;
        else          be1[lane-4] = 1'b1;
        ref_mem[(ba + i) % NB] = wd[8*i +: 8];
      end
      d0 = wd << (8 * off);
      wr_q.push_back({w0, be0, d0});
      if (split) begin
        d1 = wd >> (8 * (4 - off));
        wr_q.push_back({w1, be1, d1});
      end
      exp_q.push_back({1'b0, 32'h0});
    end else begin
      val = 32'h0;
      for (int i = 0; i < size; i++) val = val | (32'(ref_mem[(ba + i) % NB]) << (8 * i));
      if (f3 == 3'b000 && val[7])  val = val | 32'hFFFF_FF00;
      if (f3 == 3'b001 && val[15]) val = val | 32'hFFFF_0000;
      exp_q.push_back({1'b0, val});
    end
    exp_cyc_q.push_back(cyc + (split ? 3 : 2));
  endtask

  // ---------------- driver ----------------
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    int waited;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: req_ready low for %0d cycles, required high", waited);
      req_valid = 1'b0;
      return;
    end
    model_push(we, f3, addr, wd);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = $urandom();
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0 || !req_ready) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d responses, %0d writes still pending", exp_q.size(), wr_q.size());
    end
  endtask

  // ---------------- monitor ----------------
  logic [W:0]      mon_rsp;
  logic [W:0]      mon_e;
  int              mon_c;
  logic [DMA+35:0] mon_wr;
  logic [DMA+35:0] mon_ew;

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      mon_rsp = {rsp_err, rsp_rdata};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got err=%0b rdata=%h, required no response", rsp_err, rsp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        if (mon_rsp !== mon_e) begin
          n_err++;
          $display("FAIL rsp_data: got err=%0b rdata=%h required err=%0b rdata=%h",
                   mon_rsp[W], mon_rsp[W-1:0], mon_e[W], mon_e[W-1:0]);
        end
        n_cmp++;
        if (cyc != mon_c) begin
          n_err++;
          $display("FAIL rsp_latency: got cycle %0d required %0d", cyc, mon_c);
        end
      end
    end
    if (rst_n && mem_we) begin
      mon_wr = {mem_addr, mem_be, mem_wdata};
      n_cmp++;
      if (wr_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected: got addr=%0d be=%b wdata=%h, required no write", mem_addr, mem_be, mem_wdata);
      end else begin
        mon_ew = wr_q.pop_front();
        if (mon_wr !== mon_ew) begin
          n_err++;
          $display("FAIL wr_beat: got addr=%0d be=%b wdata=%h required addr=%0d be=%b wdata=%h",
                   mon_wr[DMA+35:36], mon_wr[35:32], mon_wr[31:0],
                   mon_ew[DMA+35:36], mon_ew[35:32], mon_ew[31:0]);
        end
      end
    end
    if (rst_n && !mem_we) begin
      n_cmp++;
      if (mem_be !== 4'b0000) begin
        n_err++;
        $display("FAIL be_idle: got be=%b with mem_we low, required 0000", mem_be);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [31:0] ra;
  logic [2:0]  rf;

  initial begin
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    for (int w = 0; w < (1 << DMA); w++) set_word(w, $urandom());
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_err",   64'(rsp_err),   64'd0);
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset_mem_we",    64'(mem_we),    64'd0);
    chk("reset_mem_be",    64'(mem_be),    64'd0);
    chk("reset_mem_addr",  64'(mem_addr),  64'd0);
    chk("reset_mem_wdata", 64'(mem_wdata), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    // Directed corner cases
    issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    wait_idle();
    set_word(4, 32'h80AA_5500);
    issue(1'b0, 3'b000, 32'h13, $urandom());
    issue(1'b0, 3'b100, 32'h13, $urandom());
    issue(1'b0, 3'b001, 32'h12, $urandom());
    issue(1'b0, 3'b101, 32'h12, $urandom());
    wait_idle();
    set_word(3, {16'h3344, 16'($urandom())});
    set_word(4, {16'($urandom()), 16'h1122});
    issue(1'b0, 3'b010, 32'h0E, $urandom());
    issue(1'b1, 3'b001, 32'h7FF, 32'h0000_BEEF);
    issue(1'b0, 3'b101, 32'h7FF, $urandom());
    issue(1'b1, 3'b100, 32'h20, 32'h1234_5678);
    issue(1'b0, 3'b010, 32'h20, $urandom());
    issue(1'b0, 3'b111, 32'h21, $urandom());
    issue(1'b1, 3'b010, 32'h7FD, 32'hA1B2_C3D4);
    issue(1'b0, 3'b010, 32'h7FD, $urandom());
    wait_idle();

    // Reset while ACC0 of a split store is driving the first write
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b001;
    req_addr   = 32'h7FF;
    req_wdata  = 32'h0000_5A5A;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("acc0_we_before_abort", 64'(mem_we), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_we",    64'(mem_we),    64'd0);
    chk("abort_mem_be",    64'(mem_be),    64'd0);
    chk("abort_mem_addr",  64'(mem_addr),  64'd0);
    chk("abort_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_ready", 64'(req_ready), 64'd1);
    chk("abort_top_word", 64'(mem[(1<<DMA)-1]), 64'(ref_word((1<<DMA)-1)));
    chk("abort_word0",    64'(mem[0]),          64'(ref_word(0)));

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      ra = $urandom();
      if ($urandom_range(0, 3) == 0) ra[DMA+1:2] = '1;
      else if ($urandom_range(0, 3) == 0) ra[DMA+1:2] = DMA'($urandom_range(0, 3));
      rf = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) != 0)
        while (rf == 3'b011 || rf == 3'b110 || rf == 3'b111) rf = 3'($urandom_range(0, 7));
      issue(1'($urandom_range(0, 1)), rf, ra, $urandom());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    for (int w = 0; w < (1 << DMA); w++) begin
      n_cmp++;
      if (mem[w] !== ref_word(w)) begin
        n_err++;
        $display("FAIL mem_image[%0d]: got %h required %h", w, mem[w], ref_word(w));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
